me_search_controller: RTL

Initiator side of the motion-estimation core handshake. For each macroblock of a frame, it raises start, waits for the core to acknowledge and then finish, and captures BestDist/motionX/motionY. It then publishes one result record per block plus frame-level totals. It sits between the frame scheduler (frame_start/frame_done) and the ME core (start/completed).

---
 rtl/me_search_controller_if.sv | 38 +++
 rtl/me_search_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/me_search_controller_if.sv
// Handshake and result bus between me_search_controller and its neighbours.
// Latency: none, wires only. Backpressure: none, the core paces the controller via completed.
// Carries frame_start/frame_done/busy (scheduler side), start/completed/BestDist/motionX/motionY
// (ME core side) and the per-block result record plus frame totals. master = controller,
// slave = the scheduler/core/consumer side.
interface me_search_controller_if #(
    parameter int IDX_W = 4
);
    logic             frame_start;
    logic             start;
    logic             completed;
    logic [7:0]       BestDist;
    logic [3:0]       motionX;
    logic [3:0]       motionY;
    logic [IDX_W-1:0] block_idx;
    logic             busy;
    logic             result_valid;
    logic [IDX_W-1:0] result_idx;
    logic [7:0]       result_dist;
    logic [3:0]       result_mvx;
    logic [3:0]       result_mvy;
    logic [15:0]      sad_total;
    logic [IDX_W:0]   zero_mv_cnt;
    logic             frame_done;
    logic             timeout_err;

    modport master (
        input  frame_start, completed, BestDist, motionX, motionY,
        output start, block_idx, busy, result_valid, result_idx, result_dist,
               result_mvx, result_mvy, sad_total, zero_mv_cnt, frame_done, timeout_err
    );

    modport slave (
        output frame_start, completed, BestDist, motionX, motionY,
        input  start, block_idx, busy, result_valid, result_idx, result_dist,
               result_mvx, result_mvy, sad_total, zero_mv_cnt, frame_done, timeout_err
    );
endinterface

// File: rtl/me_search_controller.sv
// Initiator for the ME core: launches one search per macroblock, captures results, keeps frame totals.
// Latency: start pulse to result_valid = 1 + ack wait + search + 2 cycles; frame_done 1 cycle after last result.
// Backpressure: waits on the core's completed level; frame_start is ignored unless idle.
// Ports: clock, reset (async, active-high), bus (me_search_controller_if.master).
// Optional: define ME_TIMEOUT_EN to add a per-phase watchdog of TIMEOUT_CYCLES that substitutes
// dist=8'hFF, mv=(0,0) for a hung search and sets the sticky timeout_err flag.
module me_search_controller #(
    parameter int NUM_BLOCKS     = 16,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    me_search_controller_if.master bus
);
    if (NUM_BLOCKS < 1 || NUM_BLOCKS > (2 ** IDX_W) || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("me_search_controller: illegal parameter combination");
    end

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_ACK  = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] CAPTURE   = 3'd4;
    localparam logic [2:0] NEXT      = 3'd5;
    localparam logic [2:0] FIN       = 3'd6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    logic [2:0]       state, state_nxt;
    logic             start_q, busy_q, result_valid_q, frame_done_q;
    logic [IDX_W-1:0] block_idx_q, result_idx_q;
    logic [7:0]       result_dist_q;
    logic [3:0]       result_mvx_q, result_mvy_q;
    logic [15:0]      sad_total_q;
    logic [IDX_W:0]   zero_mv_cnt_q;

    logic             wd_hit;     // watchdog expired in the current wait phase
    logic             timed_out;  // current block is being captured because of the watchdog
    logic [7:0]       cap_dist;
    logic [3:0]       cap_mvx, cap_mvy;
    logic             cap_zero;
    logic [16:0]      sad_sum;

`ifdef ME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          wd_fire;
    logic          timeout_err_q;

    assign wd_hit  = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
    // Fires only when the awaited edge of completed has not arrived, so a real response wins a tie.
    assign wd_fire = wd_hit && (((state == WAIT_ACK) && bus.completed) ||
                                ((state == WAIT_DONE) && !bus.completed));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt        <= '0;
            timed_out     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // Restart the count on every state change, so each wait phase gets a full budget.
            if (state != state_nxt)
                wd_cnt <= '0;
            else if (state == WAIT_ACK || state == WAIT_DONE)
                wd_cnt <= wd_cnt + TW'(1);

            if (state == LAUNCH)
                timed_out <= 1'b0;
            else if (wd_fire)
                timed_out <= 1'b1;

            if (state == CAPTURE && timed_out)
                timeout_err_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign wd_hit          = 1'b0;
    assign timed_out       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // A watchdog capture ignores whatever the core is presenting.
    assign cap_dist = timed_out ? 8'hFF : bus.BestDist;
    assign cap_mvx  = timed_out ? 4'h0  : bus.motionX;
    assign cap_mvy  = timed_out ? 4'h0  : bus.motionY;
    assign cap_zero = !timed_out && (bus.motionX == 4'h0) && (bus.motionY == 4'h0);
    assign sad_sum  = {1'b0, sad_total_q} + {9'd0, cap_dist};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.frame_start) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_ACK;
            WAIT_ACK:  if (!bus.completed) state_nxt = WAIT_DONE;
                       else if (wd_hit)   state_nxt = CAPTURE;
            WAIT_DONE: if (bus.completed || wd_hit) state_nxt = CAPTURE;
            CAPTURE:   state_nxt = NEXT;
            NEXT:      state_nxt = (block_idx_q == LAST_IDX) ? FIN : LAUNCH;
            FIN:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            block_idx_q    <= '0;
            result_idx_q   <= '0;
            result_dist_q  <= '0;
            result_mvx_q   <= '0;
            result_mvy_q   <= '0;
            sad_total_q    <= '0;
            zero_mv_cnt_q  <= '0;
        end else begin
            state          <= state_nxt;
            // Pulses are registered from the next state so they line up with LAUNCH/FIN exactly.
            start_q        <= (state_nxt == LAUNCH);
            frame_done_q   <= (state_nxt == FIN);
            result_valid_q <= (state == CAPTURE);

            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        block_idx_q   <= '0;
                        sad_total_q   <= '0;
                        zero_mv_cnt_q <= '0;
                        busy_q        <= 1'b1;
                    end
                end
                CAPTURE: begin
                    result_idx_q  <= block_idx_q;
                    result_dist_q <= cap_dist;
                    result_mvx_q  <= cap_mvx;
                    result_mvy_q  <= cap_mvy;
                    sad_total_q   <= sad_sum[16] ? 16'hFFFF : sad_sum[15:0];
                    if (cap_zero)
                        zero_mv_cnt_q <= zero_mv_cnt_q + (IDX_W + 1)'(1);
                end
                NEXT: begin
                    // block_idx keeps the last index after the frame ends.
                    if (block_idx_q != LAST_IDX)
                        block_idx_q <= block_idx_q + IDX_W'(1);
                    else
                        busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.start        = start_q;
    assign bus.busy         = busy_q;
    assign bus.block_idx    = block_idx_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_idx   = result_idx_q;
    assign bus.result_dist  = result_dist_q;
    assign bus.result_mvx   = result_mvx_q;
    assign bus.result_mvy   = result_mvy_q;
    assign bus.sad_total    = sad_total_q;
    assign bus.zero_mv_cnt  = zero_mv_cnt_q;
    assign bus.frame_done   = frame_done_q;
endmodule
